thread_stall_tracker: RTL and testbench

THREAD_STALL_TRACKER -- requirements
Module: thread_stall_tracker

---
 rtl/thread_stall_tracker.sv | 147 ++++++++++++++
 tb/tb_thread_stall_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/thread_stall_tracker.sv
// Per-thread stall tracker feeding the priority scheduler: memory waits, fixed-latency stalls, exception release.
// Optional memory-wait watchdog compiled under `STALL_TIMEOUT_EN.
module thread_stall_tracker #(
    parameter int unsigned N_THREADS = 8,
    parameter int unsigned TID_W     = 3,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_stall_en,
    input  logic [TID_W-1:0]     mem_stall_thread,
    input  logic                 mem_done_en,
    input  logic [TID_W-1:0]     mem_done_thread,
    input  logic                 lat_stall_en,
    input  logic [TID_W-1:0]     lat_stall_thread,
    input  logic [CNT_W-1:0]     lat_stall_cycles,
    input  logic                 exc_en,
    input  logic [TID_W-1:0]     exc_thread,
    output logic [N_THREADS-1:0] stalled,
    output logic                 all_stalled,
    output logic                 timeout_en,
    output logic [TID_W-1:0]     timeout_thread
);

    localparam logic [1:0] READY    = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] LAT_WAIT = 2'd2;

    // Elaboration-time parameter sanity check
    if (TIMEOUT < 1 || (1 << TID_W) < N_THREADS) begin : g_param_check
        $error("thread_stall_tracker: bad TIMEOUT or TID_W too narrow for N_THREADS");
    end

    logic [1:0]           state     [N_THREADS];
    logic [1:0]           state_nxt [N_THREADS];
    logic [CNT_W-1:0]     cnt       [N_THREADS];
    logic [CNT_W-1:0]     cnt_nxt   [N_THREADS];
    logic [N_THREADS-1:0] stalled_c;

`ifdef STALL_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TO_W-1:0]  wcnt     [N_THREADS];
    logic [TO_W-1:0]  wcnt_nxt [N_THREADS];
    logic             to_hit_c;
    logic [TID_W-1:0] to_tid_c;
`endif

    always_comb begin
`ifdef STALL_TIMEOUT_EN
        // Lowest-id saturated waiter wins; a same-cycle done/exception claims the thread instead
        to_hit_c = 1'b0;
        to_tid_c = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            if (!to_hit_c && state[i] == MEM_WAIT && wcnt[i] == TO_W'(TIMEOUT)
                && !(mem_done_en && mem_done_thread == TID_W'(i))
                && !(exc_en && exc_thread == TID_W'(i))) begin
                to_hit_c = 1'b1;
                to_tid_c = TID_W'(i);
            end
        end
`endif
        for (int i = 0; i < N_THREADS; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                READY: begin
                    if (mem_stall_en && mem_stall_thread == TID_W'(i)) begin
                        state_nxt[i] = MEM_WAIT;
                    end else if (lat_stall_en && lat_stall_thread == TID_W'(i)
                                 && lat_stall_cycles != '0) begin
                        state_nxt[i] = LAT_WAIT;
                        cnt_nxt[i]   = lat_stall_cycles;
                    end
                end
                MEM_WAIT: begin
                    if (mem_done_en && mem_done_thread == TID_W'(i)) state_nxt[i] = READY;
                end
                LAT_WAIT: begin
                    // Counter holds the remaining stalled cycles including the current one
                    if (cnt[i] == CNT_W'(1)) begin
                        state_nxt[i] = READY;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = READY;
                    cnt_nxt[i]   = '0;
                end
            endcase
`ifdef STALL_TIMEOUT_EN
            if (to_hit_c && to_tid_c == TID_W'(i)) state_nxt[i] = READY;
`endif
            if (exc_en && exc_thread == TID_W'(i)) begin
                state_nxt[i] = READY;
                cnt_nxt[i]   = '0;
            end
`ifdef STALL_TIMEOUT_EN
            if (state[i] == MEM_WAIT && state_nxt[i] == MEM_WAIT) begin
                wcnt_nxt[i] = (wcnt[i] == TO_W'(TIMEOUT)) ? wcnt[i] : wcnt[i] + TO_W'(1);
            end else begin
                wcnt_nxt[i] = '0;
            end
`endif
            stalled_c[i] = (state_nxt[i] != READY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                state[i] <= READY;
                cnt[i]   <= '0;
            end
            stalled     <= '0;
            all_stalled <= 1'b0;
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            stalled     <= stalled_c;
            all_stalled <= &stalled_c;
        end
    end

`ifdef STALL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) wcnt[i] <= '0;
            timeout_en     <= 1'b0;
            timeout_thread <= '0;
        end else begin
            for (int i = 0; i < N_THREADS; i++) wcnt[i] <= wcnt_nxt[i];
            timeout_en     <= to_hit_c;
            timeout_thread <= to_hit_c ? to_tid_c : '0;
        end
    end
`else
    assign timeout_en     = 1'b0;
    assign timeout_thread = '0;
`endif

endmodule

// File: tb/tb_thread_stall_tracker.sv
// Directed self-checking bench for thread_stall_tracker (watchdog steps run when STALL_TIMEOUT_EN is defined).
module tb_thread_stall_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_stall_en, mem_done_en, lat_stall_en, exc_en;
    logic [2:0] mem_stall_thread, mem_done_thread, lat_stall_thread, exc_thread;
    logic [3:0] lat_stall_cycles;
    logic [7:0] stalled;
    logic       all_stalled, timeout_en;
    logic [2:0] timeout_thread;

    int checks = 0;
    int errors = 0;

    thread_stall_tracker #(
        .N_THREADS(8), .TID_W(3), .CNT_W(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_stall_en(mem_stall_en), .mem_stall_thread(mem_stall_thread),
        .mem_done_en(mem_done_en), .mem_done_thread(mem_done_thread),
        .lat_stall_en(lat_stall_en), .lat_stall_thread(lat_stall_thread),
        .lat_stall_cycles(lat_stall_cycles),
        .exc_en(exc_en), .exc_thread(exc_thread),
        .stalled(stalled), .all_stalled(all_stalled),
        .timeout_en(timeout_en), .timeout_thread(timeout_thread)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_stall_en = 1'b0; mem_done_en = 1'b0; lat_stall_en = 1'b0; exc_en = 1'b0;
        mem_stall_thread = '0; mem_done_thread = '0; lat_stall_thread = '0;
        lat_stall_cycles = '0; exc_thread = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_stalled", 32'(stalled), 32'h00);
        check("rst_all", 32'(all_stalled), 32'h0);
        check("rst_to_en", 32'(timeout_en), 32'h0);
        check("rst_to_tid", 32'(timeout_thread), 32'h0);

        // Memory wait on thread 3, response five cycles later
        mem_stall_en = 1'b1; mem_stall_thread = 3'd3;
        tick(); clear_in();
        check("mem3_c1", 32'(stalled), 32'h08);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("mem3_hold", 32'(stalled), 32'h08);
        end
        mem_done_en = 1'b1; mem_done_thread = 3'd3;
        tick(); clear_in();
        check("mem3_done", 32'(stalled), 32'h00);

        // Fixed latency 4 on thread 5, then a zero-length request
        lat_stall_en = 1'b1; lat_stall_thread = 3'd5; lat_stall_cycles = 4'd4;
        tick(); clear_in();
        check("lat5_c1", 32'(stalled), 32'h20);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("lat5_hold", 32'(stalled), 32'h20);
        end
        tick();
        check("lat5_end", 32'(stalled), 32'h00);
        lat_stall_en = 1'b1; lat_stall_thread = 3'd5; lat_stall_cycles = 4'd0;
        tick(); clear_in();
        check("lat5_zero", 32'(stalled), 32'h00);

        // Same-cycle mem and lat on thread 2 -> memory wait only
        mem_stall_en = 1'b1; mem_stall_thread = 3'd2;
        lat_stall_en = 1'b1; lat_stall_thread = 3'd2; lat_stall_cycles = 4'd3;
        tick(); clear_in();
        check("t2_mem", 32'(stalled), 32'h04);
        for (int c = 0; c < 4; c++) tick();
        check("t2_no_lat_expiry", 32'(stalled), 32'h04);
        lat_stall_en = 1'b1; lat_stall_thread = 3'd2; lat_stall_cycles = 4'd1;
        tick(); clear_in();
        tick();
        check("t2_lat_ignored", 32'(stalled), 32'h04);
        exc_en = 1'b1; exc_thread = 3'd2;
        tick(); clear_in();
        check("t2_exc", 32'(stalled), 32'h00);
        mem_stall_en = 1'b1; mem_stall_thread = 3'd2; exc_en = 1'b1; exc_thread = 3'd2;
        tick(); clear_in();
        check("t2_exc_override", 32'(stalled), 32'h00);

        // Done and stall on the same READY thread -> waits
        mem_stall_en = 1'b1; mem_stall_thread = 3'd6; mem_done_en = 1'b1; mem_done_thread = 3'd6;
        tick(); clear_in();
        check("t6_done_ignored", 32'(stalled), 32'h40);
        exc_en = 1'b1; exc_thread = 3'd6;
        tick(); clear_in();
        check("t6_exc", 32'(stalled), 32'h00);

        // All threads stalled, then independent updates on distinct threads
        for (int t = 0; t < 8; t++) begin
            check("all_pre", 32'(all_stalled), 32'h0);
            mem_stall_en = 1'b1; mem_stall_thread = 3'(t);
            tick(); clear_in();
        end
        check("all_vec", 32'(stalled), 32'hFF);
        check("all_set", 32'(all_stalled), 32'h1);
        mem_done_en = 1'b1; mem_done_thread = 3'd0;
        tick(); clear_in();
        check("all_done0_vec", 32'(stalled), 32'hFE);
        check("all_done0", 32'(all_stalled), 32'h0);
        mem_done_en = 1'b1; mem_done_thread = 3'd1; mem_stall_en = 1'b1; mem_stall_thread = 3'd0;
        tick(); clear_in();
        check("indep", 32'(stalled), 32'hFD);

        // Reset mid latency stall
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clear", 32'(stalled), 32'h00);
        lat_stall_en = 1'b1; lat_stall_thread = 3'd1; lat_stall_cycles = 4'd15;
        tick(); clear_in();
        check("t1_lat", 32'(stalled), 32'h02);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t1_rst", 32'(stalled), 32'h00);
        check("t1_rst_all", 32'(all_stalled), 32'h0);
        tick();
        check("t1_after", 32'(stalled), 32'h00);

`ifdef STALL_TIMEOUT_EN
        // Watchdog: thread 4 then thread 6 time out on consecutive cycles
        mem_stall_en = 1'b1; mem_stall_thread = 3'd4;
        tick();
        mem_stall_thread = 3'd6;
        tick(); clear_in();
        for (int c = 0; c < 15; c++) begin
            check("to_quiet", 32'(timeout_en), 32'h0);
            tick();
        end
        check("to_pre_vec", 32'(stalled), 32'h50);
        check("to_pre_en", 32'(timeout_en), 32'h0);
        tick();
        check("to4_en", 32'(timeout_en), 32'h1);
        check("to4_tid", 32'(timeout_thread), 32'h4);
        check("to4_vec", 32'(stalled), 32'h40);
        tick();
        check("to6_en", 32'(timeout_en), 32'h1);
        check("to6_tid", 32'(timeout_thread), 32'h6);
        check("to6_vec", 32'(stalled), 32'h00);
        tick();
        check("to_end", 32'(timeout_en), 32'h0);

        // Done on the timeout cycle wins: no pulse
        mem_stall_en = 1'b1; mem_stall_thread = 3'd3;
        tick(); clear_in();
        for (int c = 0; c < 16; c++) tick();
        check("to3_pre", 32'(stalled), 32'h08);
        mem_done_en = 1'b1; mem_done_thread = 3'd3;
        tick(); clear_in();
        check("to3_no_pulse", 32'(timeout_en), 32'h0);
        check("to3_vec", 32'(stalled), 32'h00);
`else
        // Watchdog absent: a long memory wait never times out
        mem_stall_en = 1'b1; mem_stall_thread = 3'd4;
        tick(); clear_in();
        for (int c = 0; c < 20; c++) begin
            check("no_wd_en", 32'(timeout_en), 32'h0);
            tick();
        end
        check("no_wd_vec", 32'(stalled), 32'h10);
        check("no_wd_tid", 32'(timeout_thread), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
